alu_share_arb: RTL

//   Shares the single 64-bit ALU_64 between two requesters: req0 (execute stage, OPq)
//   and req1 (address/aux calc). Round-robin arbitration, valid/ready request handshake,
//   one-cycle registered response. Owns the condition-code register (ZF,SF,OF), which

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_share_arb_alu64.sv | 30 +++
 rtl/alu_share_arb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing block: opcodes, requester ids and
// the condition-code reset value.
package alu_pkg;

    localparam int ALU_W = 64;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam logic RID_EXE = 1'b0;
    localparam logic RID_AUX = 1'b1;

    // {ZF,SF,OF}
    localparam logic [2:0] CC_RST_DEFAULT = 3'b100;

endpackage

// File: rtl/alu_share_arb_alu64.sv
// ALU_64: purely combinational 64-bit ADD/SUB/AND/XOR with signed overflow.
module ALU_64
    import alu_pkg::*;
(
    input  logic [1:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] res,
    output logic             ovf
);

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin
                res = a + b;
                ovf = (a[ALU_W-1] == b[ALU_W-1]) && (res[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_SUB: begin
                res = a - b;
                ovf = (a[ALU_W-1] != b[ALU_W-1]) && (res[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_AND: res = a & b;
            ALU_XOR: res = a ^ b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU_64 between the execute stage (req0) and the
// aux/address unit (req1), with a registered response and the CC register.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int         DATA_W = 64,
    parameter logic [2:0] CC_RST = CC_RST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_setcc,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_ovf,
    output logic              rsp_zero,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
);

    logic              gnt_valid;
    logic              gnt_id;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;

    logic              last_gnt_q, last_gnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic [2:0]        cc_q, cc_d;

    // Grant logic; a tie goes to whoever was not served last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = RID_EXE;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_gnt_q;
            end else if (req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = RID_EXE;
            end else if (req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = RID_AUX;
            end
        end
    end

    assign req0_ready = gnt_valid && (gnt_id == RID_EXE);
    assign req1_ready = gnt_valid && (gnt_id == RID_AUX);

    assign alu_op = (gnt_id == RID_AUX) ? req1_op : req0_op;
    assign alu_a  = (gnt_id == RID_AUX) ? req1_a  : req0_a;
    assign alu_b  = (gnt_id == RID_AUX) ? req1_b  : req0_b;

    ALU_64 u_alu (
        .op  (alu_op),
        .a   (alu_a),
        .b   (alu_b),
        .res (alu_res),
        .ovf (alu_ovf)
    );

    always_comb begin
        last_gnt_d  = last_gnt_q;
        rsp_valid_d = gnt_valid;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_zero_d  = rsp_zero_q;
        cc_d        = cc_q;
        if (gnt_valid) begin
            last_gnt_d = gnt_id;
            rsp_id_d   = gnt_id;
            rsp_res_d  = alu_res;
            rsp_ovf_d  = alu_ovf;
            rsp_zero_d = (alu_res == '0);
            if (gnt_id == RID_EXE && req0_setcc) begin
                cc_d = {alu_res == '0, alu_res[DATA_W-1], alu_ovf};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q  <= RID_AUX;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= RID_EXE;
            rsp_res_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
            cc_q        <= CC_RST;
        end else begin
            last_gnt_q  <= last_gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_zero_q  <= rsp_zero_d;
            cc_q        <= cc_d;
        end
    end

    // A response already in the register is dropped as soon as rst rises.
    assign rsp_valid = rsp_valid_q && !rst;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_zero  = rsp_zero_q;
    assign {cc_zf, cc_sf, cc_of} = cc_q;

endmodule
